// File: rtl/updown_counter_mod_if.sv
// Bus bundle for updown_counter_mod.
// master: drives the control/load inputs and observes the count outputs.
// slave : the counter itself.
// Signals: enable, load, data_in, up_down, sat_mode, clr_ovf (to counter);
//          count, at_max, at_zero, tc, ovf (from counter).
// With COUNTER_CAPTURE_EN defined, capture (to counter) and cap_out (from
// counter) are added.
interface updown_counter_mod_if #(
  parameter int unsigned WIDTH = 8
);
  logic             enable;
  logic             load;
  logic [WIDTH-1:0] data_in;
  logic             up_down;
  logic             sat_mode;
  logic             clr_ovf;
  logic [WIDTH-1:0] count;
  logic             at_max;
  logic             at_zero;
  logic             tc;
  logic             ovf;
`ifdef COUNTER_CAPTURE_EN
  logic             capture;
  logic [WIDTH-1:0] cap_out;

  modport master (
    output enable, load, data_in, up_down, sat_mode, clr_ovf, capture,
    input  count, at_max, at_zero, tc, ovf, cap_out
  );
  modport slave (
    input  enable, load, data_in, up_down, sat_mode, clr_ovf, capture,
    output count, at_max, at_zero, tc, ovf, cap_out
  );
`else
  modport master (
    output enable, load, data_in, up_down, sat_mode, clr_ovf,
    input  count, at_max, at_zero, tc, ovf
  );
  modport slave (
    input  enable, load, data_in, up_down, sat_mode, clr_ovf,
    output count, at_max, at_zero, tc, ovf
  );
`endif
endinterface

// File: rtl/updown_counter_mod.sv
// General-purpose up/down event/timer counter, range 0..MODULUS-1.
// Wrap or saturate at the limits, registered terminal-count pulse (tc),
// sticky overflow flag (ovf) cleared by clr_ovf, clamped synchronous load.
// Ports: clk, rst_n (synchronous, active-low), cnt_if (slave modport of
//        updown_counter_mod_if, which must use the same WIDTH).
// Optional macro COUNTER_CAPTURE_EN adds a capture strobe and a cap_out
// register holding the pre-update count.
module updown_counter_mod #(
  parameter int unsigned      WIDTH   = 8,
  parameter longint unsigned  MODULUS = 200
) (
  input  logic                clk,
  input  logic                rst_n,
  updown_counter_mod_if.slave cnt_if
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 64'd1);

  // Reject illegal parameterisations at elaboration.
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("updown_counter_mod: WIDTH must be in 2..32");
  end
  if (MODULUS < 64'd2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
    $error("updown_counter_mod: MODULUS must be in 2..2**WIDTH");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             at_max_c, at_zero_c;
  logic             limit_evt_c;

  assign at_max_c  = (count_q == MAX_CNT);
  assign at_zero_c = (count_q == '0);

  // Next-state: load (clamped) > count > hold; limit_evt_c flags wrap/saturation.
  always_comb begin
    count_d     = count_q;
    limit_evt_c = 1'b0;
    if (cnt_if.load) begin
      count_d = (cnt_if.data_in > MAX_CNT) ? MAX_CNT : cnt_if.data_in;
    end else if (cnt_if.enable) begin
      if (cnt_if.up_down) begin
        if (at_max_c) begin
          limit_evt_c = 1'b1;
          count_d     = cnt_if.sat_mode ? count_q : '0;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (at_zero_c) begin
          limit_evt_c = 1'b1;
          count_d     = cnt_if.sat_mode ? count_q : MAX_CNT;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
    tc_d  = limit_evt_c;
    // A new event beats a simultaneous clear.
    ovf_d = limit_evt_c | (ovf_q & ~cnt_if.clr_ovf);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign cnt_if.count   = count_q;
  assign cnt_if.tc      = tc_q;
  assign cnt_if.ovf     = ovf_q;
  assign cnt_if.at_max  = at_max_c;
  assign cnt_if.at_zero = at_zero_c;

`ifdef COUNTER_CAPTURE_EN
  logic [WIDTH-1:0] cap_q, cap_d;

  // Snapshot of the count before this edge's update, independent of load/enable.
  always_comb begin
    cap_d = cnt_if.capture ? count_q : cap_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cap_q <= '0;
    end else begin
      cap_q <= cap_d;
    end
  end

  assign cnt_if.cap_out = cap_q;
`endif

endmodule

// File: tb/tb_updown_counter_mod.sv
// Directed bench for updown_counter_mod: a WIDTH=4/MODULUS=10 instance for
// the bulk of the checks and a default-parameter instance for reset and the
// 199->0 wrap. Expected results are queued when a step is driven and popped
// once the edge has happened.
module tb_updown_counter_mod;

  typedef struct {
    int cnt;
    bit tc;
    bit ovf;
    int cap;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   step_no;
  exp_t sb_q[$];
  exp_t d_q[$];

  updown_counter_mod_if #(.WIDTH(4)) s_if ();
  updown_counter_mod_if #(.WIDTH(8)) d_if ();

  updown_counter_mod #(.WIDTH(4), .MODULUS(10)) u_small (
    .clk    (clk),
    .rst_n  (rst_n),
    .cnt_if (s_if)
  );

  updown_counter_mod u_dflt (
    .clk    (clk),
    .rst_n  (rst_n),
    .cnt_if (d_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL step %0d %s observed=%0d expected=%0d", step_no, tag, obs, exp);
    end
  endtask

  // One edge on the small instance; default instance kept idle.
  task automatic step(input bit rst, input bit en, input bit ld, input int din,
                      input bit ud, input bit sat, input bit clr, input bit cap,
                      input int e_cnt, input bit e_tc, input bit e_ovf, input int e_cap);
    exp_t e;
    @(negedge clk);
    step_no++;
    rst_n           = ~rst;
    s_if.enable     = en;
    s_if.load       = ld;
    s_if.data_in    = 4'(din);
    s_if.up_down    = ud;
    s_if.sat_mode   = sat;
    s_if.clr_ovf    = clr;
`ifdef COUNTER_CAPTURE_EN
    s_if.capture    = cap;
`endif
    d_if.enable     = 1'b0;
    d_if.load       = 1'b0;
    d_if.clr_ovf    = 1'b0;
    e.cnt = e_cnt; e.tc = e_tc; e.ovf = e_ovf; e.cap = e_cap;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("count",   32'(s_if.count),   32'(e.cnt));
    chk("tc",      32'(s_if.tc),      32'(e.tc));
    chk("ovf",     32'(s_if.ovf),     32'(e.ovf));
    chk("at_max",  32'(s_if.at_max),  32'(e.cnt == 9));
    chk("at_zero", 32'(s_if.at_zero), 32'(e.cnt == 0));
`ifdef COUNTER_CAPTURE_EN
    chk("cap_out", 32'(s_if.cap_out), 32'(e.cap));
`endif
  endtask

  // One edge on the default instance; small instance kept idle.
  task automatic dstep(input bit rst, input bit en, input bit ld, input int din,
                       input int e_cnt, input bit e_tc, input bit e_ovf);
    exp_t e;
    @(negedge clk);
    step_no++;
    rst_n          = ~rst;
    d_if.enable    = en;
    d_if.load      = ld;
    d_if.data_in   = 8'(din);
    d_if.up_down   = 1'b1;
    d_if.sat_mode  = 1'b0;
    d_if.clr_ovf   = 1'b0;
    s_if.enable    = 1'b0;
    s_if.load      = 1'b0;
    s_if.clr_ovf   = 1'b0;
`ifdef COUNTER_CAPTURE_EN
    s_if.capture   = 1'b0;
`endif
    e.cnt = e_cnt; e.tc = e_tc; e.ovf = e_ovf; e.cap = 0;
    d_q.push_back(e);
    @(posedge clk);
    #1;
    e = d_q.pop_front();
    chk("d_count",   32'(d_if.count),   32'(e.cnt));
    chk("d_tc",      32'(d_if.tc),      32'(e.tc));
    chk("d_ovf",     32'(d_if.ovf),     32'(e.ovf));
    chk("d_at_max",  32'(d_if.at_max),  32'(e.cnt == 199));
    chk("d_at_zero", 32'(d_if.at_zero), 32'(e.cnt == 0));
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    step_no = 0;
    rst_n   = 1'b0;
    s_if.enable = 1'b0; s_if.load = 1'b0; s_if.data_in = '0;
    s_if.up_down = 1'b1; s_if.sat_mode = 1'b0; s_if.clr_ovf = 1'b0;
    d_if.enable = 1'b0; d_if.load = 1'b0; d_if.data_in = '0;
    d_if.up_down = 1'b1; d_if.sat_mode = 1'b0; d_if.clr_ovf = 1'b0;
`ifdef COUNTER_CAPTURE_EN
    s_if.capture = 1'b0;
    d_if.capture = 1'b0;
`endif

    // Reset, with a load requested at the same time.
    step(1, 0, 1, 7, 1, 0, 0, 1, 0, 0, 0, 0);
    step(1, 1, 1, 7, 1, 0, 0, 1, 0, 0, 0, 0);
    chk("d_reset_count", 32'(d_if.count), 32'd0);

    // Up-count with wrap: 1..9,0,1,2; tc and ovf from the 9->0 edge.
    for (int i = 1; i <= 12; i++) begin
      step(0, 1, 0, 0, 1, 0, 0, 0, i % 10, (i == 10), (i >= 10), 0);
    end

    // Down wrap, clear alone, clear colliding with a wrap.
    step(0, 0, 0, 0, 1, 0, 1, 0, 2, 0, 0, 0);
    step(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 9, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 9, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 1, 0, 9, 1, 1, 0);

    // Saturation at the top: held, tc every cycle.
    step(0, 1, 0, 0, 1, 1, 0, 0, 9, 1, 1, 0);
    step(0, 1, 0, 0, 1, 1, 0, 0, 9, 1, 1, 0);
    step(0, 1, 0, 0, 1, 1, 0, 0, 9, 1, 1, 0);
    // Saturation at the bottom.
    step(0, 0, 0, 0, 1, 1, 1, 0, 9, 0, 0, 0);
    step(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0);

    // Loads: clamp, load beats enable, ovf untouched.
    step(0, 1, 1, 12, 1, 0, 0, 0, 9, 0, 1, 0);
    step(0, 1, 1, 15, 0, 0, 0, 0, 9, 0, 1, 0);
    step(0, 1, 1, 4,  0, 0, 0, 0, 4, 0, 1, 0);
    step(0, 1, 0, 0,  0, 0, 0, 0, 3, 0, 1, 0);
    step(0, 1, 0, 0,  1, 0, 0, 0, 4, 0, 1, 0);

    // Capture sees the pre-update count, regardless of load.
    step(0, 0, 1, 5, 1, 0, 0, 0, 5, 0, 1, 0);
    step(0, 1, 0, 0, 1, 0, 0, 1, 6, 0, 1, 5);
    step(0, 1, 1, 2, 1, 0, 0, 1, 2, 0, 1, 6);
    step(0, 0, 0, 0, 1, 0, 0, 0, 2, 0, 1, 6);

    // Default parameters: wrap at 199, then reset overriding a load.
    dstep(0, 0, 1, 199, 199, 0, 0);
    dstep(0, 1, 0, 0,   0,   1, 1);
    dstep(0, 1, 0, 0,   1,   0, 1);
    dstep(0, 0, 1, 57,  57,  0, 1);
    dstep(1, 1, 1, 57,  0,   0, 0);
    dstep(0, 0, 0, 0,   0,   0, 0);

    // The shared reset also cleared the small instance.
    chk("small_reset_count", 32'(s_if.count), 32'd0);
    chk("small_reset_ovf",   32'(s_if.ovf),   32'd0);
`ifdef COUNTER_CAPTURE_EN
    chk("small_reset_cap",   32'(s_if.cap_out), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
